// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for the sequential ALU.
// master drives operations and consumes results; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALU_in1;
    logic [WIDTH-1:0] ALU_in2;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_out;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             out_err;

    modport master (
        output in_valid, ALU_in1, ALU_in2, op, out_ready,
        input  in_ready, out_valid, ALU_out,
        input  flag_z, flag_n, flag_c, flag_v, out_err
    );

    modport slave (
        input  in_valid, ALU_in1, ALU_in2, op, out_ready,
        output in_ready, out_valid, ALU_out,
        output flag_z, flag_n, flag_c, flag_v, out_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and status flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 111).
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
`ifdef ALU_MUL_EN
        MUL,
`endif
        DONE
    } state_t;

    state_t           state, nxt_state;
    logic [WIDTH-1:0] res, nxt_res;
    logic             z, n, c, v, err;
    logic             nxt_z, nxt_n, nxt_c, nxt_v, nxt_err;

    logic             in_ready;
    logic             accept;
    logic             start_mul;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic [SHW-1:0]   amt;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] shl_ext, shr_ext;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_v, op_err;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand, nxt_mcand;
    logic [2*WIDTH-1:0] acc, nxt_acc, mul_sum;
    logic [WIDTH-1:0]   mplier, nxt_mplier;
    logic [SHW-1:0]     cnt, nxt_cnt;
`endif

    assign a   = bus.ALU_in1;
    assign b   = bus.ALU_in2;
    assign op  = bus.op;
    assign amt = b[SHW-1:0];

    // A finished result frees the ALU the same cycle it is consumed.
    assign in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
`ifdef ALU_MUL_EN
    assign start_mul = accept && (op == 3'b111);
`else
    assign start_mul = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.ALU_out   = res;
    assign bus.flag_z    = z;
    assign bus.flag_n    = n;
    assign bus.flag_c    = c;
    assign bus.flag_v    = v;
    assign bus.out_err   = err;

    // Single-cycle result and flags for the operation on the inputs.
    always_comb begin
        op_res  = '0;
        op_c    = 1'b0;
        op_v    = 1'b0;
        op_err  = 1'b0;
        add_ext = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        shl_ext = {{WIDTH{1'b0}}, a} << amt;
        shr_ext = {a, {WIDTH{1'b0}}} >> amt;
        case (op)
            3'b000: begin
                op_res = add_ext[WIDTH-1:0];
                op_c   = add_ext[WIDTH];
                op_v   = (a[WIDTH-1] == b[WIDTH-1])
                      && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: op_res = a & b;
            3'b010: begin
                op_res = diff;
                op_c   = (a < b);
                op_v   = (a[WIDTH-1] != b[WIDTH-1])
                      && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: op_res = a | b;
            3'b100: op_res = a ^ b;
            3'b101: begin
                op_res = shl_ext[WIDTH-1:0];
                op_c   = shl_ext[WIDTH];
            end
            3'b110: begin
                op_res = shr_ext[2*WIDTH-1:WIDTH];
                op_c   = shr_ext[WIDTH-1];
            end
            default: begin
`ifndef ALU_MUL_EN
                op_err = 1'b1;
`endif
            end
        endcase
    end

    // Next-state, result capture and multiplier iteration.
    always_comb begin
        nxt_state = state;
        nxt_res   = res;
        nxt_z     = z;
        nxt_n     = n;
        nxt_c     = c;
        nxt_v     = v;
        nxt_err   = err;
`ifdef ALU_MUL_EN
        nxt_mcand  = mcand;
        nxt_acc    = acc;
        nxt_mplier = mplier;
        nxt_cnt    = cnt;
        mul_sum    = acc + (mplier[0] ? mcand : '0);
`endif
        case (state)
            IDLE, DONE: begin
                if (accept && !start_mul) begin
                    nxt_res   = op_res;
                    nxt_z     = (op_res == '0);
                    nxt_n     = op_res[WIDTH-1];
                    nxt_c     = op_c;
                    nxt_v     = op_v;
                    nxt_err   = op_err;
                    nxt_state = DONE;
                end
`ifdef ALU_MUL_EN
                else if (start_mul) begin
                    nxt_mcand  = {{WIDTH{1'b0}}, a};
                    nxt_mplier = b;
                    nxt_acc    = '0;
                    nxt_cnt    = '0;
                    nxt_state  = MUL;
                end
`endif
                else if ((state == DONE) && bus.out_ready) begin
                    nxt_state = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                nxt_acc    = mul_sum;
                nxt_mcand  = mcand << 1;
                nxt_mplier = mplier >> 1;
                nxt_cnt    = cnt + 1'b1;
                if (cnt == SHW'(WIDTH - 1)) begin
                    nxt_res   = mul_sum[WIDTH-1:0];
                    nxt_z     = (mul_sum[WIDTH-1:0] == '0);
                    nxt_n     = mul_sum[WIDTH-1];
                    nxt_c     = |mul_sum[2*WIDTH-1:WIDTH];
                    nxt_v     = 1'b0;
                    nxt_err   = 1'b0;
                    nxt_state = DONE;
                end
            end
`endif
            default: nxt_state = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res   <= '0;
            z     <= 1'b0;
            n     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            state <= nxt_state;
            res   <= nxt_res;
            z     <= nxt_z;
            n     <= nxt_n;
            c     <= nxt_c;
            v     <= nxt_v;
            err   <= nxt_err;
`ifdef ALU_MUL_EN
            mcand  <= nxt_mcand;
            acc    <= nxt_acc;
            mplier <= nxt_mplier;
            cnt    <= nxt_cnt;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// arithmetic reference model; follows ALU_MUL_EN like the design.
module tb_alu_seq;
    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON  = 1'b1;
    localparam int MUL_LAT = W + 1;
`else
    localparam bit MUL_ON  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic exp_t model(input logic [2:0] o,
                                   input logic [15:0] a,
                                   input logic [15:0] b);
        exp_t        e;
        int          s;
        int          ss;
        longint      p;
        logic [15:0] x;
        e = '0;
        case (o)
            3'd0: begin
                s     = int'(a) + int'(b);
                e.res = s[15:0];
                e.c   = (s > 65535);
                ss    = int'($signed(a)) + int'($signed(b));
                e.v   = (ss > 32767) || (ss < -32768);
            end
            3'd1: e.res = a & b;
            3'd2: begin
                s     = int'(a) - int'(b);
                e.res = s[15:0];
                e.c   = (a < b);
                ss    = int'($signed(a)) - int'($signed(b));
                e.v   = (ss > 32767) || (ss < -32768);
            end
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin
                x = a;
                repeat (int'(b[3:0])) begin
                    e.c = x[15];
                    x   = x << 1;
                end
                e.res = x;
            end
            3'd6: begin
                x = a;
                repeat (int'(b[3:0])) begin
                    e.c = x[0];
                    x   = x >> 1;
                end
                e.res = x;
            end
            default: begin
                if (MUL_ON) begin
                    p     = longint'(a) * longint'(b);
                    e.res = p[15:0];
                    e.c   = (p > 65535);
                end else begin
                    e.err = 1'b1;
                end
            end
        endcase
        e.z = (e.res == 16'h0000);
        e.n = e.res[15];
        return e;
    endfunction

    function automatic exp_t obs();
        return {bus.ALU_out, bus.flag_z, bus.flag_n,
                bus.flag_c, bus.flag_v, bus.out_err};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.op      = 3'($urandom);
        bus.ALU_in1 = 16'($urandom);
        bus.ALU_in2 = 16'($urandom);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, output int lat,
                          output exp_t got);
        int guard;
        guard       = 0;
        bus.op      = o;
        bus.ALU_in1 = a;
        bus.ALU_in2 = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        got = obs();
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t zero;
        zero = '0;
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (obs() !== zero || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b want %h/0",
                     obs(), bus.out_valid, zero);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready %b out_valid %b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_add_sub();
        int   lat;
        exp_t got, want;
        run_op(3'd0, 16'hFFFF, 16'h0001, lat, got);
        want = {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (lat !== 1 || got !== want) begin
            n_fail++;
            $display("FAIL add_wrap: got %h lat %0d want %h lat 1",
                     got, lat, want);
        end
        take();
        run_op(3'd2, 16'h8000, 16'h0001, lat, got);
        want = {16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_tests++;
        if (lat !== 1 || got !== want) begin
            n_fail++;
            $display("FAIL sub_ovf: got %h lat %0d want %h lat 1",
                     got, lat, want);
        end
        take();
        run_op(3'd2, 16'h0001, 16'h0002, lat, got);
        want = {16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h want %h", got, want);
        end
        take();
    endtask

    task automatic test_stall_b2b();
        int   lat;
        int   bad;
        exp_t got, want;
        run_op(3'd5, 16'h8001, 16'h0001, lat, got);
        want = {16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL shl_carry: got %h want %h", got, want);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs() !== want || bus.out_valid !== 1'b1
                || bus.in_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles want 0", bad);
        end
        bus.op        = 3'd1;
        bus.ALU_in1   = 16'h0F0F;
        bus.ALU_in2   = 16'h00FF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: in_ready %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        scramble();
        want = {16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (bus.out_valid !== 1'b1 || obs() !== want) begin
            n_fail++;
            $display("FAIL b2b_and: got %h valid %b want %h valid 1",
                     obs(), bus.out_valid, want);
        end
        take();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int   lat;
        int   bad;
        exp_t got, want;
        bus.op       = 3'd7;
        bus.ALU_in1  = 16'h0123;
        bus.ALU_in2  = 16'h0010;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        scramble();
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mul_busy: %0d bad cycles want 0", bad);
        end
        want = {16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (bus.out_valid !== 1'b1 || obs() !== want) begin
            n_fail++;
            $display("FAIL mul_small: got %h valid %b want %h valid 1",
                     obs(), bus.out_valid, want);
        end
        take();
        run_op(3'd7, 16'h0100, 16'h0100, lat, got);
        want = {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (lat !== 17 || got !== want) begin
            n_fail++;
            $display("FAIL mul_ovf: got %h lat %0d want %h lat 17",
                     got, lat, want);
        end
        take();
    endtask
`else
    task automatic test_mul_off();
        int   lat;
        exp_t got, want;
        run_op(3'd7, 16'h0003, 16'h0004, lat, got);
        want = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        n_tests++;
        if (lat !== 1 || got !== want) begin
            n_fail++;
            $display("FAIL mul_off: got %h lat %0d want %h lat 1",
                     got, lat, want);
        end
        take();
        run_op(3'd0, 16'h0001, 16'h0001, lat, got);
        want = {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL err_clear: got %h want %h", got, want);
        end
        take();
    endtask
`endif

    task automatic test_reset_abort();
        int   lat;
        exp_t got, want, zero;
        zero = '0;
`ifdef ALU_MUL_EN
        bus.op       = 3'd7;
        bus.ALU_in1  = 16'h1234;
        bus.ALU_in2  = 16'h5678;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
`else
        run_op(3'd4, 16'h1234, 16'h5678, lat, got);
        repeat (2) tick();
`endif
        rst = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || obs() !== zero
            || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: got %h valid %b rdy %b want 0/0/1",
                     obs(), bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        run_op(3'd0, 16'h0002, 16'h0003, lat, got);
        want = {16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (lat !== 1 || got !== want) begin
            n_fail++;
            $display("FAIL after_reset_add: got %h lat %0d want %h lat 1",
                     got, lat, want);
        end
        take();
    endtask

    task automatic test_random();
        int          lat;
        exp_t        got, want;
        logic [2:0]  o;
        logic [15:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            want = model(o, a, b);
            run_op(o, a, b, lat, got);
            n_tests++;
            if (lat !== ((o == 3'd7) ? MUL_LAT : 1) || got !== want) begin
                n_fail++;
                $display("FAIL rand op%0d %h %h: got %h lat %0d want %h",
                         o, a, b, got, lat, want);
            end
            repeat ($urandom_range(0, 2)) tick();
            take();
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        exp_t        got, want;
        logic [2:0]  o;
        logic [15:0] a, b;
        o = 3'($urandom_range(0, 6));
        a = pick();
        b = pick();
        run_op(o, a, b, lat, got);
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            want = model(o, a, b);
            bus.op        = o;
            bus.ALU_in1   = a;
            bus.ALU_in2   = b;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            scramble();
            lat = 1;
            while (!bus.out_valid && lat < 200) begin
                tick();
                lat++;
            end
            n_tests++;
            if (lat !== ((o == 3'd7) ? MUL_LAT : 1) || obs() !== want) begin
                n_fail++;
                $display("FAIL b2b op%0d %h %h: got %h lat %0d want %h",
                         o, a, b, obs(), lat, want);
            end
        end
        take();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'd0;
        bus.ALU_in1   = 16'h0000;
        bus.ALU_in2   = 16'h0000;
        test_reset();
        test_add_sub();
        test_stall_b2b();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_mul_off();
`endif
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
